// File: rtl/pipe_pkg.sv
// Encodings and types shared between the ID-stage control unit and the hazard controller.
package pipe_pkg;

  localparam logic [1:0] HILO_NONE   = 2'b00;
  localparam logic [1:0] HILO_MULDIV = 2'b01;
  localparam logic [1:0] HILO_MFHI   = 2'b10;
  localparam logic [1:0] HILO_MFLO   = 2'b11;

  typedef enum logic {IDLE, BUSY} hazard_state_t;

endpackage

// File: rtl/muldiv_timer.sv
// Tracks an in-flight mult/div operation: busy for MULDIV_CYCLES cycles after start,
// then a one-cycle done pulse in the first idle cycle.
module muldiv_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int unsigned CntW = $clog2(MULDIV_CYCLES + 1);

  hazard_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = CntW'(MULDIV_CYCLES);
        end
      end
      BUSY: begin
        if (cnt_q == CntW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == BUSY);
    done = done_q;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use detection, HI/LO resource stalls, IF flush gating
// and a saturating count of bubble cycles.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_ex_memread,
  input  logic [4:0]             id_ex_rt,
  input  logic [4:0]             if_id_rs,
  input  logic [4:0]             if_id_rt,
  input  logic [1:0]             id_hilo,
  input  logic                   branch_taken,
  output logic                   bubble_sel,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_flush,
  output logic                   muldiv_start,
  output logic                   muldiv_busy,
  output logic                   muldiv_done,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic lu, hh, stall;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  muldiv_timer #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv_timer (
    .clk  (clk),
    .rst  (rst),
    .start(muldiv_start),
    .busy (muldiv_busy),
    .done (muldiv_done)
  );

  always_comb begin
    lu = id_ex_memread && (id_ex_rt != 5'd0) &&
         ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    hh = muldiv_busy && (id_hilo != HILO_NONE);
    stall = lu || hh;
  end

  always_comb begin
    bubble_sel   = stall;
    pc_write     = !stall;
    if_id_write  = !stall;
    if_flush     = branch_taken && !stall;
    // An issue blocked by a load-use hazard simply retries next cycle.
    muldiv_start = !muldiv_busy && (id_hilo == HILO_MULDIV) && !lu;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
